// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// vec_mem_pkg : shared vector-memory widths, lane vector type, port owners
// Rev 1.0
// ============================================================================
package vec_mem_pkg;

  localparam int I = 32;
  localparam int N = 8;
  localparam int R = 6;

  typedef logic [R-1:0][N-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DISP = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/dmem_starve_timer.sv
`default_nettype none
// ============================================================================
// dmem_starve_timer : saturating lost-cycle counter that forces a grant
// Rev 1.0
// ============================================================================
module dmem_starve_timer #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_gnt,
  input  logic i_lose,
  output logic o_force
);

  localparam int              c_CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_WAIT);

  logic [c_CNT_W-1:0] r_cnt;

  // Clearing on every grant guarantees no two forced grants in a row.
  always_ff @(posedge clk) begin
    if (!reset || !i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (i_lose && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign o_force = i_req && (r_cnt == c_MAX);

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_port_arbiter : shares data_mem between the vector CPU and display fetch
// Rev 1.0
// ============================================================================
module dmem_port_arbiter #(
  parameter int I        = 32,
  parameter int N        = 8,
  parameter int R        = 6,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [I-1:0]         cpu_addr,
  input  logic [R-1:0][N-1:0]  cpu_wdata,
  output logic [R-1:0][N-1:0]  cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 disp_req,
  input  logic [I-1:0]         disp_addr,
  output logic                 disp_gnt,
  output logic                 disp_rvalid,
  output logic [R-1:0][N-1:0]  disp_rdata,
  output logic                 mem_we,
  output logic [I-1:0]         mem_addr,
  output logic [R-1:0][N-1:0]  mem_wdata,
  input  logic [R-1:0][N-1:0]  mem_rdata,
  output logic [CW-1:0]        stall_count
);

  import vec_mem_pkg::*;

  owner_t                w_owner;
  logic                  w_force;
  logic                  w_lose;
  logic                  r_disp_rvalid;
  logic [R-1:0][N-1:0]   r_disp_rdata;
  logic [CW-1:0]         r_stall_count;

  dmem_starve_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .i_req   (disp_req),
    .i_gnt   (disp_gnt),
    .i_lose  (w_lose),
    .o_force (w_force)
  );

  always_comb begin
    w_owner = OWN_NONE;
    if (w_force) begin
      w_owner = OWN_DISP;
    end else if (cpu_req) begin
      w_owner = OWN_CPU;
    end else if (disp_req) begin
      w_owner = OWN_DISP;
    end
  end

  // Strobes are gated by reset so nothing reaches memory while held in reset.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    disp_gnt  = 1'b0;
    case (w_owner)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & reset;
      end
      OWN_DISP: begin
        mem_addr  = disp_addr;
        disp_gnt  = reset;
      end
      default: ;
    endcase
  end

  assign w_lose    = disp_req && (w_owner == OWN_CPU);
  assign cpu_stall = w_force & cpu_req & reset;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_disp_rvalid <= 1'b0;
      r_disp_rdata  <= '0;
      r_stall_count <= '0;
    end else begin
      r_disp_rvalid <= disp_gnt;
      if (disp_gnt) begin
        r_disp_rdata <= mem_rdata;
      end
      if (cpu_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CW'(1);
      end
    end
  end

  assign disp_rvalid = r_disp_rvalid;
  assign disp_rdata  = r_disp_rdata;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_port_arbiter : scoreboard bench for the data_mem port arbiter
// Rev 1.0
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int I  = 32;
  localparam int N  = 8;
  localparam int R  = 6;
  localparam int CW = 4;
  localparam logic [47:0] c_W1 = 48'hDEAD_BEEF_0123;
  localparam logic [47:0] c_W2 = 48'hCAFE_F00D_4567;

  logic          clk;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [I-1:0]  cpu_addr;
  logic [47:0]   cpu_wdata;
  logic [47:0]   cpu_rdata;
  logic          cpu_stall;
  logic          disp_req;
  logic [I-1:0]  disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [47:0]   disp_rdata;
  logic          mem_we;
  logic [I-1:0]  mem_addr;
  logic [47:0]   mem_wdata;
  logic [47:0]   mem_rdata;
  logic [CW-1:0] stall_count;

  logic [47:0]   mem [0:255];
  logic [47:0]   sb_q [$];
  int            n_cmp;
  int            n_bad;

  dmem_port_arbiter #(
    .I(I), .N(N), .R(R), .MAX_WAIT(4), .CW(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] pat(input int a);
    return {6{8'(a) ^ 8'hC3}};
  endfunction

  // Behavioural data_mem: asynchronous read, write on the clock edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
  end
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && disp_rvalid) begin
      if (sb_q.size() == 0) begin
        check("rvalid_unexpected", 64'(disp_rvalid), 64'(0));
      end else begin
        check("disp_rdata", 64'(disp_rdata), 64'(sb_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    disp_req = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // Reset with both requesters active: nothing may reach memory.
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = c_W1;
    disp_req = 1'b1; disp_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_gnt", 64'(disp_gnt), 64'(0));
    check("rst_stall", 64'(cpu_stall), 64'(0));
    check("rst_rvalid", 64'(disp_rvalid), 64'(0));
    check("rst_stall_cnt", 64'(stall_count), 64'(0));
    step(); reset = 1'b1; idle();
    @(negedge clk);
    check("idle_mem_we", 64'(mem_we), 64'(0));

    // Display only.
    step(); disp_req = 1'b1; disp_addr = 32'h10;
    @(negedge clk);
    check("disp_gnt", 64'(disp_gnt), 64'(1));
    check("disp_mem_we", 64'(mem_we), 64'(0));
    check("disp_mem_addr", 64'(mem_addr), 64'h10);
    sb_q.push_back(pat(32'h10));
    step(); disp_req = 1'b0;
    @(negedge clk);
    check("disp_rvalid", 64'(disp_rvalid), 64'(1));
    step();
    @(negedge clk);
    check("rvalid_pulse", 64'(disp_rvalid), 64'(0));

    // CPU write then read back.
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = c_W1;
    @(negedge clk);
    check("cpu_mem_we", 64'(mem_we), 64'(1));
    check("cpu_mem_addr", 64'(mem_addr), 64'h20);
    check("cpu_mem_wdata", 64'(mem_wdata), 64'(c_W1));
    check("cpu_no_stall", 64'(cpu_stall), 64'(0));
    step(); cpu_we = 1'b0;
    @(negedge clk);
    check("cpu_rdata", 64'(cpu_rdata), 64'(c_W1));

    // Starvation: forced display grant every fifth cycle.
    for (int k = 0; k < 10; k++) begin
      step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      disp_req = 1'b1; disp_addr = 32'h50;
      @(negedge clk);
      check("starve_gnt", 64'(disp_gnt), 64'((k % 5) == 4));
      check("starve_stall", 64'(cpu_stall), 64'((k % 5) == 4));
      if ((k % 5) == 4) begin
        sb_q.push_back(pat(32'h50));
        check("forced_mem_addr", 64'(mem_addr), 64'h50);
        check("forced_mem_we", 64'(mem_we), 64'(0));
      end
    end
    step(); idle();
    @(negedge clk);
    check("stall_cnt_2", 64'(stall_count), 64'(2));

    // CPU write and display read of the same address in the same cycle.
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = c_W2;
    disp_req = 1'b1; disp_addr = 32'h30;
    @(negedge clk);
    check("wr_rd_gnt0", 64'(disp_gnt), 64'(0));
    check("wr_rd_we", 64'(mem_we), 64'(1));
    step(); cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("wr_rd_gnt1", 64'(disp_gnt), 64'(1));
    sb_q.push_back(c_W2);
    step(); idle();
    @(negedge clk);

    // Reset asserted in what would be a grant cycle.
    step(); reset = 1'b0; disp_req = 1'b1; disp_addr = 32'h10;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = c_W1;
    @(negedge clk);
    check("mid_rst_gnt", 64'(disp_gnt), 64'(0));
    check("mid_rst_mem_we", 64'(mem_we), 64'(0));
    step(); reset = 1'b1; idle();
    @(negedge clk);
    check("post_rst_rvalid", 64'(disp_rvalid), 64'(0));
    check("post_rst_stall_cnt", 64'(stall_count), 64'(0));

    // Twenty forced stalls saturate the 4-bit counter at 15.
    for (int k = 0; k < 100; k++) begin
      step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      disp_req = 1'b1; disp_addr = 32'h50;
      @(negedge clk);
      if ((k % 5) == 4) sb_q.push_back(pat(32'h50));
      if (k == 50) check("sat_cnt_10", 64'(stall_count), 64'(10));
      if (k == 75) check("sat_cnt_15", 64'(stall_count), 64'(15));
    end
    step(); idle();
    @(negedge clk);
    check("sat_cnt_hold", 64'(stall_count), 64'(15));
    step();
    @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data_mem port between the vector CPU (load/store) and the VGA display fetch engine (read-only pixel/vector fetch).
- CPU has priority by default. A starvation timer forces a display grant after MAX_WAIT lost cycles and stalls the CPU for that cycle.
- Sits between cpu, the display fetcher and data_mem in top. It replaces the direct cpu→data_mem connection.

Parameters:
- I, 32, address width
- N, 8, lane width in bits
- R, 6, number of lanes per memory word
- MAX_WAIT, 4, display lost cycles before a forced grant; 0 = display has fixed priority
- CW, 16, width of the saturating stall counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU memory access this cycle
- cpu_we  in  1  CPU write enable
- cpu_addr  in  I  CPU address
- cpu_wdata  in  R×N  CPU write vector
- cpu_rdata  out  R×N  read vector to CPU (combinational from mem_rdata)
- cpu_stall  out  1  CPU must hold its request; port taken by display
- disp_req  in  1  display read request; held with disp_addr stable until disp_gnt
- disp_addr  in  I  display read address
- disp_gnt  out  1  display owns the port this cycle
- disp_rvalid  out  1  disp_rdata valid, one cycle after disp_gnt
- disp_rdata  out  R×N  registered read vector to display
- mem_we  out  1  to data_mem WE
- mem_addr  out  I  to data_mem A
- mem_wdata  out  R×N  to data_mem WD
- mem_rdata  in  R×N  from data_mem RD (asynchronous read)
- stall_count  out  CW  saturating count of cpu_stall cycles

Behaviour:
- Registered state: starve_cnt (0..MAX_WAIT), disp_rvalid, disp_rdata, stall_count.
- Owner selection is combinational each cycle, in priority order:
  1. disp_req && starve_cnt==MAX_WAIT → DISP (forced); cpu_stall = cpu_req.
  2. cpu_req → CPU.
  3. disp_req → DISP.
  4. Otherwise → NONE.
- Owner CPU: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we. cpu_rdata=mem_rdata in the same cycle (zero latency, unchanged CPU timing).
- Owner DISP: mem_addr=disp_addr, mem_we=0, mem_wdata=0, disp_gnt=1. At the edge, disp_rdata<=mem_rdata and disp_rvalid<=1.
- Owner NONE: mem_we=0, mem_addr=0. disp_rvalid<=0 on the edge.
- disp_rvalid is a one-cycle pulse per grant. disp_rdata holds its last value between grants.
- starve_cnt update:
  - cleared when disp_gnt or !disp_req;
  - incremented when disp_req && owner==CPU;
  - saturates at MAX_WAIT.
- No two consecutive forced grants: starve_cnt clears on every grant.
- stall_count increments on each cycle with cpu_stall=1 and saturates at 2^CW−1.
- cpu_stall=1 only in a forced-grant cycle with cpu_req=1. The CPU re-presents the same access next cycle, where it wins because starve_cnt=0.
- With MAX_WAIT=0, display wins every cycle it requests.
- Reset (reset==0 at a clk edge):
  - starve_cnt, disp_rvalid, disp_rdata and stall_count are cleared.
  - While reset is low, mem_we, disp_gnt and cpu_stall are forced to 0 combinationally.
  - A pending disp_rvalid is dropped, with no pulse after reset.
- Simultaneous CPU write and display read on the same address: serialized by owner order. A display read granted the cycle after a CPU write returns the new data.

Decomposition:
- Package vec_mem_pkg holds:
  - localparams I, N, R;
  - typedef lane_vec_t = logic [R-1:0][N-1:0];
  - enum owner_t {OWN_NONE, OWN_CPU, OWN_DISP}.
- One sub-module, dmem_starve_timer: the saturating starve_cnt plus a force output. It is reusable when a third requester (interpreter readout) is added.

Test Plan:
- Display only: disp_req=1, disp_addr=0x10, mem holds V → disp_gnt same cycle; disp_rvalid=1 next cycle with disp_rdata=V; mem_we=0.
- CPU only: cpu_req=1, cpu_we=1, cpu_addr=0x20, wdata=W → mem_we=1, mem_addr=0x20 same cycle; cpu_stall=0. Following CPU read of 0x20 → cpu_rdata=W.
- Starvation, MAX_WAIT=4: cpu_req and disp_req held high → CPU owns cycles 0–3; cycle 4 has disp_gnt=1, cpu_stall=1; cycle 5 CPU owns again; the pattern repeats every 5 cycles; stall_count=2 after 10 cycles.
- Write-then-read: CPU writes 0x30=W at cycle 0 while disp_req for 0x30 → display is granted at cycle 1 and disp_rdata=W at cycle 2.
- Reset mid-operation: assert reset low in the cycle of disp_gnt → next cycle disp_rvalid=0; starve_cnt=0, stall_count=0; mem_we=0 throughout reset.
- Saturation: CW=4, force 20 stall cycles → stall_count stops at 15.
